// File: rtl/occ_multichan_capture_ctrl_if.sv
// occ_multichan_capture_ctrl_if: valid/ready config port carrying per-channel pulse widths.
interface occ_multichan_capture_ctrl_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int MAX_PULSES   = 8
);
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int WW = $clog2(MAX_PULSES + 1);
   logic          valid;
   logic          ready;
   logic [CW-1:0] chan;
   logic [WW-1:0] width;
   modport master (output valid, chan, width, input ready);
   modport slave  (input valid, chan, width, output ready);
endinterface

// File: rtl/occ_multichan_capture_ctrl.sv
// occ_multichan_capture_ctrl: on-chip clock controller driving per-channel gate enables
// from a scan-loaded capture mask segment, with per-channel pulse widths.
module occ_multichan_capture_ctrl #(
   parameter int NUM_CHANNELS = 4,
   parameter int MAX_PULSES   = 8,
   parameter int SYNC_CYCLES  = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        test_mode,
   input  logic                        fast_capture_mode,
   input  logic                        kill_clock_en,
   input  logic                        scan_en,
   input  logic                        scan_in,
   output logic                        scan_out,
   occ_multichan_capture_ctrl_if.slave cfg,
   output logic [NUM_CHANNELS-1:0]     clock_en,
   output logic                        capture_active,
   output logic                        capture_done
);
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int WW = $clog2(MAX_PULSES + 1);
   localparam int KW = (MAX_PULSES > 1) ? $clog2(MAX_PULSES) : 1;
   localparam int NW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
   localparam int SL = NUM_CHANNELS * MAX_PULSES;
   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;
   state_t        state, state_nxt;
   logic [SL-1:0] seg;
   logic [WW-1:0] width [NUM_CHANNELS];
   logic [KW-1:0] k;
   logic [NW-1:0] cnt;
   logic          scan_en_q;
   assign cfg.ready = ~reset & (state == IDLE);
   // channel c owns seg[c*MAX_PULSES +: MAX_PULSES]; channel 0 sits nearest scan_out
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         seg          <= '0;
         k            <= '0;
         cnt          <= '0;
         scan_en_q    <= 1'b0;
         scan_out     <= 1'b0;
         capture_done <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++) width[c] <= WW'(MAX_PULSES);
      end else begin
         state        <= state_nxt;
         scan_en_q    <= scan_en;
         scan_out     <= test_mode & seg[0];
         capture_done <= (state_nxt == DONE) && (state != DONE);
         cnt          <= (state == WAIT) ? cnt - NW'(1) : NW'(SYNC_CYCLES - 1);
         k            <= (state == CAPTURE) ? k + KW'(1) : '0;
         if (test_mode & scan_en) seg <= SL'({scan_in, seg} >> 1);
         if (cfg.valid & cfg.ready)
            for (int c = 0; c < NUM_CHANNELS; c++)
               if (cfg.chan == CW'(c))
                  width[c] <= (cfg.width > WW'(MAX_PULSES)) ? WW'(MAX_PULSES) : cfg.width;
      end
   end
   always_comb begin
      state_nxt      = state;
      capture_active = (state == CAPTURE);
      clock_en       = '0;
      unique case (state)
         IDLE:    state_nxt = (scan_en_q & ~scan_en) ? WAIT : IDLE;
         WAIT:    state_nxt = scan_en ? IDLE : (cnt == '0) ? CAPTURE : WAIT;
         CAPTURE: state_nxt = scan_en ? IDLE : (k == KW'(MAX_PULSES - 1)) ? DONE : CAPTURE;
         DONE:    state_nxt = scan_en ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
      if (!test_mode || !fast_capture_mode) state_nxt = IDLE;
      // fast capture indexes the mask by k so the loaded pattern survives the window
      for (int c = 0; c < NUM_CHANNELS; c++)
         clock_en[c] = !test_mode ? ~kill_clock_en :
                       !fast_capture_mode ? (scan_en | (seg[c*MAX_PULSES] & (|width[c]))) :
                       (capture_active & seg[c*MAX_PULSES + int'(k)] & (WW'(k) < width[c]));
   end
endmodule
